// File: rtl/haraka_pkg.sv
// Shared Haraka-S sponge definitions: squeeze FSM encoding and rate geometry.
package haraka_pkg;

  localparam int unsigned RATE_BITS  = 256;
  localparam int unsigned RATE_BYTES = RATE_BITS / 8;

  typedef enum logic [1:0] {
    SqIdle      = 2'd0,
    SqWaitBlock = 2'd1,
    SqShift     = 2'd2,
    SqDone      = 2'd3
  } sq_state_t;

endpackage

// File: rtl/squeeze_serializer.sv
// Haraka-S squeeze stage: pulls rate blocks from the permutation core and streams
// them out LSB byte first until the requested byte count is reached.
module squeeze_serializer
  import haraka_pkg::*;
#(
  parameter int unsigned BlockWidth = RATE_BITS,
  parameter int unsigned OutWidth   = 8,
  parameter int unsigned LenWidth   = 16
) (
  input  logic                  clk_i,
  input  logic                  clear_i,
  input  logic                  start_i,
  input  logic [LenWidth-1:0]   out_len_i,
  input  logic [BlockWidth-1:0] block_in_i,
  input  logic                  block_valid_i,
  output logic                  block_ready_o,
  output logic [OutWidth-1:0]   serial_out_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int unsigned WordsPerBlock = BlockWidth / OutWidth;
  localparam int unsigned IdxWidth      = $clog2(WordsPerBlock);
  localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(WordsPerBlock - 1);

  sq_state_t             state_q, state_d;
  logic [BlockWidth-1:0] shift_q, shift_d;
  logic [LenWidth-1:0]   remaining_q, remaining_d;
  logic [IdxWidth-1:0]   byte_idx_q, byte_idx_d;

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    remaining_d = remaining_q;
    byte_idx_d  = byte_idx_q;
    unique case (state_q)
      SqIdle: begin
        if (start_i) begin
          if (out_len_i != '0) begin
            remaining_d = out_len_i;
            state_d     = SqWaitBlock;
          end else begin
            state_d = SqDone;
          end
        end
      end
      SqWaitBlock: begin
        if (block_valid_i) begin
          shift_d    = block_in_i;
          byte_idx_d = '0;
          state_d    = SqShift;
        end
      end
      SqShift: begin
        if (out_ready_i) begin
          shift_d     = shift_q >> OutWidth;
          remaining_d = (remaining_q != '0) ? remaining_q - 1'b1 : '0;
          byte_idx_d  = byte_idx_q + 1'b1;
          // Length exhaustion wins over block end; leftover bytes are dropped.
          if (remaining_q == LenWidth'(1)) begin
            state_d = SqDone;
          end else if (byte_idx_q == LastIdx) begin
            state_d = SqWaitBlock;
          end
        end
      end
      SqDone: begin
        state_d = SqIdle;
      end
      default: begin
        state_d = SqIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      state_q     <= SqIdle;
      shift_q     <= '0;
      remaining_q <= '0;
      byte_idx_q  <= '0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      remaining_q <= remaining_d;
      byte_idx_q  <= byte_idx_d;
    end
  end

  assign block_ready_o = (state_q == SqWaitBlock);
  assign out_valid_o   = (state_q == SqShift);
  assign busy_o        = (state_q != SqIdle);
  assign done_o        = (state_q == SqDone);
  assign serial_out_o  = shift_q[OutWidth-1:0];

endmodule

// File: tb/tb_squeeze_serializer.sv
// Directed bench for squeeze_serializer: byte order, block handshakes, stalls, clear, start masking.
module tb_squeeze_serializer;

  logic         clk = 1'b0;
  logic         clear;
  logic         start;
  logic [15:0]  out_len;
  logic [255:0] block_in;
  logic         block_valid;
  logic         block_ready;
  logic [7:0]   serial_out;
  logic         out_valid;
  logic         out_ready;
  logic         busy;
  logic         done;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  squeeze_serializer dut (
    .clk_i        (clk),
    .clear_i      (clear),
    .start_i      (start),
    .out_len_i    (out_len),
    .block_in_i   (block_in),
    .block_valid_i(block_valid),
    .block_ready_o(block_ready),
    .serial_out_o (serial_out),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .busy_o       (busy),
    .done_o       (done)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Block k carries bytes 32k .. 32k+31, byte 0 in the LSBs.
  function automatic logic [255:0] mk_block(input int k);
    logic [255:0] b;
    for (int j = 0; j < 32; j++) b[8*j +: 8] = 8'(32 * k + j);
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_busy"}, 64'(busy), 64'd0);
    check_eq({tag, "_done"}, 64'(done), 64'd0);
    check_eq({tag, "_block_ready"}, 64'(block_ready), 64'd0);
    check_eq({tag, "_out_valid"}, 64'(out_valid), 64'd0);
  endtask

  // Runs one squeeze of len bytes with block_valid held high throughout.
  task automatic run_squeeze(input int len, input bit stall, input bit poke,
                             output int nbytes, output int nblocks, output int ndone);
    int         last_xfer = -10;
    int         s = 0;
    bit         held_v = 0;
    logic [7:0] held = '0;
    nbytes  = 0;
    nblocks = 0;
    ndone   = 0;
    start   = 1'b1;
    out_len = 16'(len);
    tick();
    start   = 1'b0;
    out_len = 16'd0;
    if (len == 0) begin
      check_eq("len0_done", 64'(done), 64'd1);
      check_eq("len0_block_ready", 64'(block_ready), 64'd0);
      ndone = 1;
      tick();
      check_idle("len0_after");
      return;
    end
    check_eq("start_busy", 64'(busy), 64'd1);
    check_eq("start_block_ready", 64'(block_ready), 64'd1);
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (done) begin
        ndone++;
        check_eq("done_timing", 64'(cyc), 64'(last_xfer + 1));
        break;
      end
      if (held_v) begin
        check_eq("stall_valid", 64'(out_valid), 64'd1);
        check_eq("stall_hold", 64'(serial_out), 64'(held));
      end
      held_v      = 0;
      block_in    = mk_block(nblocks);
      block_valid = 1'b1;
      if (block_ready) nblocks++;
      out_ready = stall ? (s % 3 == 0) : 1'b1;
      start     = poke && out_valid && (nbytes == 2);
      out_len   = poke ? 16'd40 : 16'd0;
      if (out_valid) begin
        s++;
        if (out_ready) begin
          check_eq("byte", 64'(serial_out), 64'(nbytes & 8'hff));
          nbytes++;
          last_xfer = cyc;
        end else begin
          held_v = 1;
          held   = serial_out;
        end
      end
      tick();
    end
    if (ndone == 0) check_eq("done_timeout", 64'd0, 64'd1);
    start       = 1'b0;
    block_valid = 1'b0;
    out_ready   = 1'b0;
    tick();
    check_idle("after_done");
  endtask

  initial begin
    int nb, nk, nd;
    clear       = 1'b1;
    start       = 1'b0;
    out_len     = '0;
    block_in    = '0;
    block_valid = 1'b0;
    out_ready   = 1'b0;
    tick();
    tick();
    check_idle("reset");
    check_eq("reset_serial_out", 64'(serial_out), 64'd0);
    clear = 1'b0;
    tick();
    check_idle("post_reset");

    run_squeeze(32, 1'b0, 1'b0, nb, nk, nd);
    check_eq("l32_bytes", 64'(nb), 64'd32);
    check_eq("l32_blocks", 64'(nk), 64'd1);
    check_eq("l32_dones", 64'(nd), 64'd1);

    run_squeeze(40, 1'b0, 1'b0, nb, nk, nd);
    check_eq("l40_bytes", 64'(nb), 64'd40);
    check_eq("l40_blocks", 64'(nk), 64'd2);
    check_eq("l40_dones", 64'(nd), 64'd1);

    run_squeeze(0, 1'b0, 1'b0, nb, nk, nd);
    check_eq("l0_blocks", 64'(nk), 64'd0);

    run_squeeze(4, 1'b1, 1'b0, nb, nk, nd);
    check_eq("stall_bytes", 64'(nb), 64'd4);
    check_eq("stall_dones", 64'(nd), 64'd1);

    run_squeeze(6, 1'b0, 1'b1, nb, nk, nd);
    check_eq("poke_bytes", 64'(nb), 64'd6);
    check_eq("poke_blocks", 64'(nk), 64'd1);

    // Clear after 10 of 32 bytes.
    start   = 1'b1;
    out_len = 16'd32;
    tick();
    start       = 1'b0;
    block_in    = mk_block(3);
    block_valid = 1'b1;
    out_ready   = 1'b1;
    tick();
    block_valid = 1'b0;
    check_eq("clr_first_byte", 64'(serial_out), 64'h60);
    for (int i = 0; i < 10; i++) tick();
    check_eq("clr_byte10", 64'(serial_out), 64'h6a);
    clear = 1'b1;
    tick();
    clear     = 1'b0;
    out_ready = 1'b0;
    check_idle("clear");
    check_eq("clear_serial_out", 64'(serial_out), 64'd0);
    run_squeeze(2, 1'b0, 1'b0, nb, nk, nd);
    check_eq("after_clr_bytes", 64'(nb), 64'd2);
    check_eq("after_clr_blocks", 64'(nk), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
